snn_lif_layer_tm: RTL and testbench

Parametrised, time-multiplexed leaky integrate-and-fire (LIF) layer. This is the successor to the fixed-size two-layer SNN neuron array.
- Consumes one binary input spike vector per timestep over a valid/ready handshake.
- Integrates programmable signed weights into per-neuron membrane potentials.
- Applies shift-based leak, threshold, reset mode and refractory period.
- Emits one output spike vector per timestep.
- Instances chain output-to-input to build multi-layer networks.

---
 rtl/snn_pkg.sv | 57 +++++
 rtl/snn_lif_layer_tm_lif_update.sv | 67 ++++++
 rtl/snn_lif_layer_tm.sv | 170 +++++++++++++++++
 tb/tb_snn_lif_layer_tm.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// -----------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the time-multiplexed LIF layer:
//   - state_t          : layer FSM encoding
//   - RESET_TO_ZERO /
//     RESET_SUBTRACT   : membrane behaviour after a spike
//   - acc_width()      : width of the per-neuron input accumulator
//   - idx_width()      : counter/address width for a given element count
//   - refr_width()     : refractory counter width
//   - sat_w()          : signed saturation of a wide value to a given width
// -----------------------------------------------------------------------------
package snn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_UPDATE = 2'd2,
      ST_OUTPUT = 2'd3
   } state_t;

   localparam int RESET_TO_ZERO  = 0;
   localparam int RESET_SUBTRACT = 1;

   // Width used internally by sat_w; wide enough for any realistic WIDTH.
   localparam int SAT_BITS = 64;

   // Sum of N_IN weights needs clog2(N_IN) extra bits; two more cover the
   // leak subtraction and the membrane add without overflow.
   function automatic int acc_width(input int width, input int n_in);
      return width + $clog2(n_in) + 2;
   endfunction

   function automatic int idx_width(input int count);
      return (count > 1) ? $clog2(count) : 1;
   endfunction

   function automatic int refr_width(input int refract);
      return (refract > 0) ? $clog2(refract + 1) : 1;
   endfunction

   // Clamp a signed value to [-2^(width-1), 2^(width-1)-1].
   function automatic logic signed [SAT_BITS-1:0] sat_w(
      input logic signed [SAT_BITS-1:0] value,
      input int                         width
   );
      logic signed [SAT_BITS-1:0] max_v;
      logic signed [SAT_BITS-1:0] min_v;
      max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (width - 1));
      if (value > max_v)
         return max_v;
      else if (value < min_v)
         return min_v;
      return value;
   endfunction

endpackage

// File: rtl/snn_lif_layer_tm_lif_update.sv
// -----------------------------------------------------------------------------
// lif_update
// Purely combinational membrane update for one neuron per timestep.
//   v         : current membrane potential (signed, WIDTH)
//   acc       : weighted input sum for this timestep (signed, ACC_W)
//   threshold : firing threshold (signed, WIDTH)
//   refr      : remaining refractory timesteps
//   v_next    : membrane potential to store back
//   spike     : neuron fires this timestep
//   refr_next : refractory count to store back
// -----------------------------------------------------------------------------
module lif_update
   import snn_pkg::*;
#(
   parameter  int WIDTH      = 16,
   parameter  int N_IN       = 2,
   parameter  int LEAK_SHIFT = 3,
   parameter  int REFRACT    = 2,
   parameter  int RESET_MODE = RESET_TO_ZERO,
   localparam int ACC_W      = acc_width(WIDTH, N_IN),
   localparam int REFR_W     = refr_width(REFRACT)
) (
   input  logic signed [WIDTH-1:0]  v,
   input  logic signed [ACC_W-1:0]  acc,
   input  logic signed [WIDTH-1:0]  threshold,
   input  logic        [REFR_W-1:0] refr,
   output logic signed [WIDTH-1:0]  v_next,
   output logic                     spike,
   output logic        [REFR_W-1:0] refr_next
);

   logic signed [ACC_W-1:0] v_ext;
   logic signed [ACC_W-1:0] leak;
   logic signed [ACC_W-1:0] v_sum;
   logic signed [WIDTH-1:0] v_sat;
   logic signed [WIDTH-1:0] v_sub;

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch.
      v_next    = '0;
      spike     = 1'b0;
      refr_next = refr;

      v_ext = {{(ACC_W-WIDTH){v[WIDTH-1]}}, v};
      // A shift of zero would cancel the whole membrane; zero means no leak.
      if (LEAK_SHIFT == 0)
         leak = '0;
      else
         leak = v_ext >>> LEAK_SHIFT;
      v_sum = v_ext - leak + acc;
      v_sat = WIDTH'(sat_w({{(SAT_BITS-ACC_W){v_sum[ACC_W-1]}}, v_sum}, WIDTH));
      v_sub = WIDTH'(sat_w({{(SAT_BITS-WIDTH){v_sat[WIDTH-1]}}, v_sat}
                         - {{(SAT_BITS-WIDTH){threshold[WIDTH-1]}}, threshold}, WIDTH));

      if (refr != '0) begin
         // Refractory: silent and clamped to rest, inputs are discarded.
         refr_next = refr - REFR_W'(1);
      end else if (v_sat >= threshold) begin
         spike     = 1'b1;
         refr_next = REFR_W'(REFRACT);
         v_next    = (RESET_MODE == RESET_SUBTRACT) ? v_sub : '0;
      end else begin
         v_next = v_sat;
      end
   end

endmodule

// File: rtl/snn_lif_layer_tm.sv
// -----------------------------------------------------------------------------
// snn_lif_layer_tm
// Time-multiplexed leaky integrate-and-fire layer. One input spike vector is
// accepted per timestep, each neuron accumulates its weighted inputs one input
// per cycle, then its membrane is updated; the output spike vector is held
// until downstream accepts it.
//   clk, reset          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input timestep handshake
//   in_spikes           : binary input vector (N_IN)
//   threshold           : signed threshold, sampled on input accept
//   wr_en/wr_addr/wr_data : weight write port (index n*N_IN+i), IDLE only
//   out_valid/out_ready : output timestep handshake
//   out_spikes          : output spike vector (N_OUT)
//   busy                : a timestep is in progress
// -----------------------------------------------------------------------------
module snn_lif_layer_tm
   import snn_pkg::*;
#(
   parameter  int WIDTH      = 16,
   parameter  int N_IN       = 2,
   parameter  int N_OUT      = 3,
   parameter  int LEAK_SHIFT = 3,
   parameter  int REFRACT    = 2,
   parameter  int RESET_MODE = RESET_TO_ZERO,
   localparam int N_W        = N_IN * N_OUT,
   localparam int ADDR_W     = idx_width(N_W)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [N_IN-1:0]         in_spikes,
   input  logic signed [WIDTH-1:0] threshold,
   input  logic                    wr_en,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic signed [WIDTH-1:0] wr_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [N_OUT-1:0]        out_spikes,
   output logic                    busy
);

   localparam int ACC_W  = acc_width(WIDTH, N_IN);
   localparam int REFR_W = refr_width(REFRACT);
   localparam int IW     = idx_width(N_IN);
   localparam int NW     = idx_width(N_OUT);

   state_t                  state;
   logic signed [WIDTH-1:0] weight   [N_W];
   logic signed [WIDTH-1:0] v_mem    [N_OUT];
   logic [REFR_W-1:0]       refr_mem [N_OUT];

   logic [N_IN-1:0]         spikes_lat;
   logic signed [WIDTH-1:0] thr_lat;
   logic signed [ACC_W-1:0] acc;
   logic [IW-1:0]           i_idx;
   logic [NW-1:0]           n_idx;
   logic [N_OUT-1:0]        spike_vec;      // spikes of neurons already updated
   logic [N_OUT-1:0]        spike_vec_next;

   logic [ADDR_W-1:0]       w_idx;
   logic signed [WIDTH-1:0] w_cur;
   logic signed [WIDTH-1:0] v_next;
   logic                    spike;
   logic [REFR_W-1:0]       refr_next;

   assign w_idx = ADDR_W'(int'(n_idx) * N_IN + int'(i_idx));
   assign w_cur = weight[w_idx];

   always_comb begin
      spike_vec_next        = spike_vec;
      spike_vec_next[n_idx] = spike;
   end

   lif_update #(
      .WIDTH      (WIDTH),
      .N_IN       (N_IN),
      .LEAK_SHIFT (LEAK_SHIFT),
      .REFRACT    (REFRACT),
      .RESET_MODE (RESET_MODE)
   ) u_lif_update (
      .v         (v_mem[n_idx]),
      .acc       (acc),
      .threshold (thr_lat),
      .refr      (refr_mem[n_idx]),
      .v_next    (v_next),
      .spike     (spike),
      .refr_next (refr_next)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         // NOTE: the weight, membrane and refractory arrays are cleared by
         // reset, so they are flop arrays rather than inferred RAM.
         for (int k = 0; k < N_W; k++)   weight[k]   <= '0;
         for (int k = 0; k < N_OUT; k++) v_mem[k]    <= '0;
         for (int k = 0; k < N_OUT; k++) refr_mem[k] <= '0;
         spikes_lat <= '0;
         thr_lat    <= '0;
         acc        <= '0;
         i_idx      <= '0;
         n_idx      <= '0;
         spike_vec  <= '0;
         in_ready   <= 1'b1;
         busy       <= 1'b0;
         out_valid  <= 1'b0;
         out_spikes <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch below
         // reads the values registered before this edge.
         // A write in the accept cycle lands before the first ACCUM read.
         if (state == ST_IDLE && wr_en && int'(wr_addr) < N_W)
            weight[wr_addr] <= wr_data;

         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  spikes_lat <= in_spikes;
                  thr_lat    <= threshold;
                  n_idx      <= '0;
                  i_idx      <= '0;
                  acc        <= '0;
                  spike_vec  <= '0;
                  in_ready   <= 1'b0;
                  busy       <= 1'b1;
                  state      <= ST_ACCUM;
               end
            end

            ST_ACCUM: begin
               if (spikes_lat[i_idx])
                  acc <= acc + {{(ACC_W-WIDTH){w_cur[WIDTH-1]}}, w_cur};
               if (i_idx == IW'(N_IN - 1))
                  state <= ST_UPDATE;
               else
                  i_idx <= i_idx + IW'(1);
            end

            ST_UPDATE: begin
               v_mem[n_idx]    <= v_next;
               refr_mem[n_idx] <= refr_next;
               spike_vec       <= spike_vec_next;
               acc             <= '0;
               i_idx           <= '0;
               if (n_idx == NW'(N_OUT - 1)) begin
                  out_spikes <= spike_vec_next;
                  out_valid  <= 1'b1;
                  state      <= ST_OUTPUT;
               end else begin
                  n_idx <= n_idx + NW'(1);
                  state <= ST_ACCUM;
               end
            end

            ST_OUTPUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_snn_lif_layer_tm.sv
// -----------------------------------------------------------------------------
// tb_snn_lif_layer_tm
// Directed bench for snn_lif_layer_tm. Instance a uses the default parameters
// (reset-to-zero, REFRACT=2); instance b uses subtract-threshold reset with no
// refractory period. Weight-write and reset inputs are shared; each instance
// has its own handshake. Expected spikes are hand-computed in the tables.
// -----------------------------------------------------------------------------
module tb_snn_lif_layer_tm;

   typedef struct {
      logic [1:0]         spikes;
      logic signed [15:0] thr;
      logic [2:0]         exp;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic               in_valid_a, in_valid_b, out_ready_a, out_ready_b;
   logic [1:0]         in_spikes;
   logic signed [15:0] threshold;
   logic               wr_en;
   logic [2:0]         wr_addr;
   logic signed [15:0] wr_data;
   logic               in_ready_a, in_ready_b, out_valid_a, out_valid_b;
   logic               busy_a, busy_b;
   logic [2:0]         out_spikes_a, out_spikes_b;

   int n_checks = 0;
   int n_errors = 0;

   snn_lif_layer_tm #(
      .WIDTH(16), .N_IN(2), .N_OUT(3), .LEAK_SHIFT(3), .REFRACT(2), .RESET_MODE(0)
   ) dut_a (
      .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .in_spikes(in_spikes), .threshold(threshold), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .out_valid(out_valid_a),
      .out_ready(out_ready_a), .out_spikes(out_spikes_a), .busy(busy_a)
   );

   snn_lif_layer_tm #(
      .WIDTH(16), .N_IN(2), .N_OUT(3), .LEAK_SHIFT(3), .REFRACT(0), .RESET_MODE(1)
   ) dut_b (
      .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in_spikes(in_spikes), .threshold(threshold), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .out_valid(out_valid_b),
      .out_ready(out_ready_b), .out_spikes(out_spikes_b), .busy(busy_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic get_in_ready(input bit sel);
      return sel ? in_ready_b : in_ready_a;
   endfunction

   function automatic logic get_out_valid(input bit sel);
      return sel ? out_valid_b : out_valid_a;
   endfunction

   function automatic logic [2:0] get_out_spikes(input bit sel);
      return sel ? out_spikes_b : out_spikes_a;
   endfunction

   function automatic logic get_out_ready(input bit sel);
      return sel ? out_ready_b : out_ready_a;
   endfunction

   task automatic set_valid(input bit sel, input logic val);
      if (sel) in_valid_b = val;
      else     in_valid_a = val;
   endtask

   // All tasks are entered and left 1 time unit after a rising edge.
   task automatic write_w(input logic [2:0] addr, input logic signed [15:0] data);
      wr_en   = 1'b1;
      wr_addr = addr;
      wr_data = data;
      @(posedge clk); #1;
      wr_en   = 1'b0;
   endtask

   task automatic set_all(input logic signed [15:0] data);
      for (int k = 0; k < 6; k++) write_w(3'(k), data);
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      #3;
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic do_accept(input bit sel, input logic [1:0] spk, input logic signed [15:0] thr,
                            input string name);
      int waited = 0;
      in_spikes = spk;
      threshold = thr;
      set_valid(sel, 1'b1);
      while (!get_in_ready(sel) && waited < 40) begin
         @(posedge clk); #1;
         waited++;
      end
      check({name, " in_ready"}, 32'(get_in_ready(sel)), 32'd1);
      @(posedge clk); #1;
      set_valid(sel, 1'b0);
   endtask

   task automatic wait_out(input bit sel, input logic [2:0] exp, input int exp_lat,
                           input string name);
      int cyc = 0;
      while (!get_out_valid(sel) && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({name, " latency"}, 32'(cyc), 32'(exp_lat));
      check({name, " spikes"}, 32'(get_out_spikes(sel)), 32'(exp));
      if (get_out_ready(sel)) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic run_vec(input bit sel, input vec_t v, input string name);
      do_accept(sel, v.spikes, v.thr, name);
      wait_out(sel, v.exp, 9, name);
   endtask

   vec_t basic_tab [6];
   vec_t sub_tab   [6];
   vec_t mix_tab   [5];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // W=10 everywhere, thr=25; leak 1/8, refractory 2.
      basic_tab = '{
         '{2'b11, 16'sd25, 3'b000},   // v=20
         '{2'b11, 16'sd25, 3'b111},   // 20-2+20=38 fires
         '{2'b11, 16'sd25, 3'b000},   // refractory
         '{2'b11, 16'sd25, 3'b000},   // refractory
         '{2'b11, 16'sd25, 3'b000},   // v=20
         '{2'b11, 16'sd25, 3'b111}    // 38 fires
      };
      // Subtract mode, no refractory.
      sub_tab = '{
         '{2'b11, 16'sd25, 3'b000},   // v=20
         '{2'b11, 16'sd25, 3'b111},   // 38 -> v=13
         '{2'b11, 16'sd25, 3'b111},   // 13-1+20=32 -> v=7
         '{2'b11, 16'sd25, 3'b111},   // 7-0+20=27 -> v=2
         '{2'b11, 16'sd25, 3'b000},   // 2+20=22
         '{2'b11, 16'sd25, 3'b111}    // 22-2+20=40 -> v=15
      };
      // W: n0=(30,0) n1=(0,30) n2=(-5,10), thr=25.
      mix_tab = '{
         '{2'b01, 16'sd25, 3'b001},   // n0=30 fires, n1=0, n2=-5
         '{2'b10, 16'sd25, 3'b010},   // n0 refr, n1=30 fires, n2=-5+1+10=6
         '{2'b11, 16'sd25, 3'b000},   // n0,n1 refr, n2=11
         '{2'b00, 16'sd25, 3'b000},   // n0=0, n1 refr, n2=10
         '{2'b11, 16'sd25, 3'b011}    // n0=30, n1=30, n2=14
      };

      reset       = 1'b0;
      in_valid_a  = 1'b0;
      in_valid_b  = 1'b0;
      out_ready_a = 1'b1;
      out_ready_b = 1'b1;
      in_spikes   = '0;
      threshold   = '0;
      wr_en       = 1'b0;
      wr_addr     = '0;
      wr_data     = '0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state.
      check("rst out_valid", 32'(out_valid_a), 32'd0);
      check("rst out_spikes", 32'(out_spikes_a), 32'd0);
      check("rst in_ready", 32'(in_ready_a), 32'd1);
      check("rst busy", 32'(busy_a), 32'd0);
      check("rst in_ready b", 32'(in_ready_b), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;

      // Basic fire, reset-to-zero, refractory.
      set_all(16'sd10);
      for (int k = 0; k < 6; k++) run_vec(1'b0, basic_tab[k], $sformatf("basic%0d", k + 1));

      // Subtract-threshold mode on the second instance.
      for (int k = 0; k < 6; k++) run_vec(1'b1, sub_tab[k], $sformatf("sub%0d", k + 1));

      // Mixed weights and input patterns.
      pulse_reset();
      write_w(3'd0, 16'sd30);
      write_w(3'd3, 16'sd30);
      write_w(3'd4, -16'sd5);
      write_w(3'd5, 16'sd10);
      for (int k = 0; k < 5; k++) run_vec(1'b0, mix_tab[k], $sformatf("mix%0d", k + 1));

      // Positive saturation: 65534 clamps to 32767, which equals thr.
      pulse_reset();
      set_all(16'sd32767);
      run_vec(1'b0, '{2'b11, 16'sd32767, 3'b111}, "sat_pos");

      // Negative saturation: a wrapped value would be positive and fire at thr=0.
      pulse_reset();
      set_all(-16'sd20000);
      for (int k = 0; k < 3; k++)
         run_vec(1'b0, '{2'b11, 16'sd0, 3'b000}, $sformatf("sat_neg%0d", k + 1));

      // Backpressure: output held, new input ignored until the handshake.
      pulse_reset();
      set_all(16'sd20);
      out_ready_a = 1'b0;
      do_accept(1'b0, 2'b11, 16'sd25, "bp");
      wait_out(1'b0, 3'b111, 9, "bp");
      in_spikes  = 2'b00;
      in_valid_a = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check($sformatf("bp hold%0d out_valid", k), 32'(out_valid_a), 32'd1);
         check($sformatf("bp hold%0d spikes", k), 32'(out_spikes_a), 32'b111);
         check($sformatf("bp hold%0d in_ready", k), 32'(in_ready_a), 32'd0);
      end
      out_ready_a = 1'b1;
      @(posedge clk); #1;
      check("bp release out_valid", 32'(out_valid_a), 32'd0);
      check("bp release in_ready", 32'(in_ready_a), 32'd1);
      @(posedge clk); #1;
      in_valid_a = 1'b0;
      check("bp accept busy", 32'(busy_a), 32'd1);
      wait_out(1'b0, 3'b000, 9, "bp next");

      // Weight write while busy is ignored.
      pulse_reset();
      set_all(16'sd10);
      do_accept(1'b0, 2'b11, 16'sd25, "wbusy");
      write_w(3'd0, 16'sd100);
      wait_out(1'b0, 3'b000, 8, "wbusy");
      run_vec(1'b0, '{2'b11, 16'sd25, 3'b111}, "wbusy step2");

      // Write in the same IDLE cycle as accept is used by that timestep.
      pulse_reset();
      set_all(16'sd10);
      wr_en   = 1'b1;
      wr_addr = 3'd0;
      wr_data = 16'sd100;
      do_accept(1'b0, 2'b11, 16'sd25, "widle");
      wr_en = 1'b0;
      wait_out(1'b0, 3'b001, 9, "widle");

      // Asynchronous reset in the middle of ACCUM.
      set_all(16'sd30);
      do_accept(1'b0, 2'b11, 16'sd25, "rstacc");
      #2 reset = 1'b0;
      #1;
      check("rstacc out_valid", 32'(out_valid_a), 32'd0);
      check("rstacc busy", 32'(busy_a), 32'd0);
      check("rstacc in_ready", 32'(in_ready_a), 32'd1);
      #2 reset = 1'b1;
      @(posedge clk); #1;
      run_vec(1'b0, '{2'b11, 16'sd25, 3'b000}, "rstacc after");

      // Asynchronous reset while an output is held.
      set_all(16'sd30);
      out_ready_a = 1'b0;
      do_accept(1'b0, 2'b11, 16'sd25, "rstout");
      wait_out(1'b0, 3'b111, 9, "rstout");
      #2 reset = 1'b0;
      #1;
      check("rstout out_valid", 32'(out_valid_a), 32'd0);
      check("rstout out_spikes", 32'(out_spikes_a), 32'd0);
      check("rstout in_ready", 32'(in_ready_a), 32'd1);
      #2 reset = 1'b1;
      @(posedge clk); #1;
      out_ready_a = 1'b1;
      run_vec(1'b0, '{2'b11, 16'sd25, 3'b000}, "rstout after");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
